// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and branch flush control.
// The stage either captures the decoded instruction or loads a bubble; it never holds its contents.
module id_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic [1:0]       ResultSrcD,
    input  logic [2:0]       ALUControlD,
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    input  logic [WIDTH-1:0] PCD,
    input  logic [WIDTH-1:0] ImmExtD,
    input  logic [WIDTH-1:0] PCPlus4D,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             PCSrcE,

    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             JumpE,
    output logic             BranchE,
    output logic             ALUSrcE,
    output logic [1:0]       ResultSrcE,
    output logic [2:0]       ALUControlE,
    output logic [WIDTH-1:0] RD1E,
    output logic [WIDTH-1:0] RD2E,
    output logic [WIDTH-1:0] PCE,
    output logic [WIDTH-1:0] ImmExtE,
    output logic [WIDTH-1:0] PCPlus4E,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic             ValidE,

    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE
);

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       jump;
        logic       branch;
        logic       alusrc;
        logic [1:0] resultsrc;
        logic [2:0] aluctl;
    } ctrl_t;

    typedef struct packed {
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] pcplus4;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
    } data_t;

    ctrl_t ctrl_reg, ctrl_next;
    data_t data_reg, data_next;
    logic  valid_reg, valid_next;
    logic  lw_stall;
    logic  flush_e;

    // Only a real load in execute with a non-x0 destination can stall decode;
    // a bubble carries ValidE=0 so it can never trigger this.
    assign lw_stall = valid_reg
                    & (ctrl_reg.resultsrc == RESULT_LOAD)
                    & (data_reg.rd != 5'd0)
                    & ((data_reg.rd == Rs1D) | (data_reg.rd == Rs2D));

    assign flush_e = lw_stall | PCSrcE;

    always_comb begin
        ctrl_next  = '{regwrite:  RegWriteD,
                       memwrite:  MemWriteD,
                       jump:      JumpD,
                       branch:    BranchD,
                       alusrc:    ALUSrcD,
                       resultsrc: ResultSrcD,
                       aluctl:    ALUControlD};
        data_next  = '{rd1:     RD1D,
                       rd2:     RD2D,
                       pc:      PCD,
                       imm:     ImmExtD,
                       pcplus4: PCPlus4D,
                       rs1:     Rs1D,
                       rs2:     Rs2D,
                       rd:      RdD};
        valid_next = 1'b1;
        if (flush_e) begin
            ctrl_next  = '0;
            data_next  = '0;
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_reg  <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            ctrl_reg  <= ctrl_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
        end
    end

    assign RegWriteE   = ctrl_reg.regwrite;
    assign MemWriteE   = ctrl_reg.memwrite;
    assign JumpE       = ctrl_reg.jump;
    assign BranchE     = ctrl_reg.branch;
    assign ALUSrcE     = ctrl_reg.alusrc;
    assign ResultSrcE  = ctrl_reg.resultsrc;
    assign ALUControlE = ctrl_reg.aluctl;
    assign RD1E        = data_reg.rd1;
    assign RD2E        = data_reg.rd2;
    assign PCE         = data_reg.pc;
    assign ImmExtE     = data_reg.imm;
    assign PCPlus4E    = data_reg.pcplus4;
    assign Rs1E        = data_reg.rs1;
    assign Rs2E        = data_reg.rs2;
    assign RdE         = data_reg.rd;
    assign ValidE      = valid_reg;

    // A redirect and a load-use stall may coincide: fetch/decode hold, decode is squashed,
    // and the redirect still wins because FlushD overrides the held IF/ID contents.
    assign StallF = lw_stall;
    assign StallD = lw_stall;
    assign FlushD = PCSrcE;
    assign FlushE = flush_e;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard table followed by randomized cycles
// checked against a pipeline-slot model.
module tb_id_ex_stage;

    localparam int WIDTH = 32;

    typedef struct {
        logic             reset;
        logic             pcsrc;
        logic             regwrite;
        logic             memwrite;
        logic             jump;
        logic             branch;
        logic             alusrc;
        logic [1:0]       resultsrc;
        logic [2:0]       aluctl;
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] pcp4;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
    } din_t;

    typedef struct {
        din_t       d;
        logic       exp_stall;
        logic       exp_fd;
        logic       exp_fe;
        logic       exp_valid;
        logic       exp_rw;
        logic [4:0] exp_rd;
        logic       exp_br;
        logic       exp_jmp;
    } row_t;

    logic             clk;
    logic             reset;
    logic             RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]       ResultSrcD;
    logic [2:0]       ALUControlD;
    logic [WIDTH-1:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
    logic [4:0]       Rs1D, Rs2D, RdD;
    logic             PCSrcE;
    logic             RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]       ResultSrcE;
    logic [2:0]       ALUControlE;
    logic [WIDTH-1:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0]       Rs1E, Rs2E, RdE;
    logic             ValidE, StallF, StallD, FlushD, FlushE;

    int total = 0;
    int bad   = 0;

    // Reference: contents of the execute slot as an instruction record
    din_t m_e;
    logic m_valid;

    logic obs_stallf, obs_stalld, obs_fd, obs_fe;

    id_ex_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCSrcE(PCSrcE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic din_t zero_din();
        din_t z;
        z = '{default: '0};
        return z;
    endfunction

    function automatic din_t rand_din(input logic [4:0] regmax);
        din_t d;
        d.reset     = ($urandom_range(0, 31) == 0);
        d.pcsrc     = ($urandom_range(0, 7) == 0);
        d.regwrite  = 1'($urandom);
        d.memwrite  = 1'($urandom);
        d.jump      = 1'($urandom);
        d.branch    = 1'($urandom);
        d.alusrc    = 1'($urandom);
        d.resultsrc = 2'($urandom);
        d.aluctl    = 3'($urandom);
        d.rd1       = $urandom;
        d.rd2       = $urandom;
        d.pc        = $urandom;
        d.imm       = $urandom;
        d.pcp4      = $urandom;
        d.rs1       = 5'($urandom_range(0, int'(regmax)));
        d.rs2       = 5'($urandom_range(0, int'(regmax)));
        d.rd        = 5'($urandom_range(0, int'(regmax)));
        return d;
    endfunction

    function automatic row_t mk(input logic rst, input logic pcs, input logic rw,
                                input logic [1:0] rsrc, input logic br, input logic jmp,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic es, input logic efd, input logic efe,
                                input logic ev, input logic erw, input logic [4:0] erd,
                                input logic ebr, input logic ejmp);
        row_t r;
        r.d           = rand_din(5'd31);
        r.d.reset     = rst;
        r.d.pcsrc     = pcs;
        r.d.regwrite  = rw;
        r.d.resultsrc = rsrc;
        r.d.branch    = br;
        r.d.jump      = jmp;
        r.d.rs1       = rs1;
        r.d.rs2       = rs2;
        r.d.rd        = rd;
        r.exp_stall = es;  r.exp_fd = efd;  r.exp_fe = efe;
        r.exp_valid = ev;  r.exp_rw = erw;  r.exp_rd = erd;
        r.exp_br    = ebr; r.exp_jmp = ejmp;
        return r;
    endfunction

    task automatic drive(input din_t d);
        reset       = d.reset;
        PCSrcE      = d.pcsrc;
        RegWriteD   = d.regwrite;
        MemWriteD   = d.memwrite;
        JumpD       = d.jump;
        BranchD     = d.branch;
        ALUSrcD     = d.alusrc;
        ResultSrcD  = d.resultsrc;
        ALUControlD = d.aluctl;
        RD1D        = d.rd1;
        RD2D        = d.rd2;
        PCD         = d.pc;
        ImmExtD     = d.imm;
        PCPlus4D    = d.pcp4;
        Rs1D        = d.rs1;
        Rs2D        = d.rs2;
        RdD         = d.rd;
    endtask

    task automatic check_e_vs_model();
        chk("ValidE", 64'(ValidE), 64'(m_valid));
        chk("RegWriteE", 64'(RegWriteE), 64'(m_e.regwrite));
        chk("MemWriteE", 64'(MemWriteE), 64'(m_e.memwrite));
        chk("JumpE", 64'(JumpE), 64'(m_e.jump));
        chk("BranchE", 64'(BranchE), 64'(m_e.branch));
        chk("ALUSrcE", 64'(ALUSrcE), 64'(m_e.alusrc));
        chk("ResultSrcE", 64'(ResultSrcE), 64'(m_e.resultsrc));
        chk("ALUControlE", 64'(ALUControlE), 64'(m_e.aluctl));
        chk("RD1E", 64'(RD1E), 64'(m_e.rd1));
        chk("RD2E", 64'(RD2E), 64'(m_e.rd2));
        chk("PCE", 64'(PCE), 64'(m_e.pc));
        chk("ImmExtE", 64'(ImmExtE), 64'(m_e.imm));
        chk("PCPlus4E", 64'(PCPlus4E), 64'(m_e.pcp4));
        chk("Rs1E", 64'(Rs1E), 64'(m_e.rs1));
        chk("Rs2E", 64'(Rs2E), 64'(m_e.rs2));
        chk("RdE", 64'(RdE), 64'(m_e.rd));
    endtask

    // One clock: drive D inputs, check hazard outputs against the model slot,
    // advance the model across the edge, then check the new slot contents.
    task automatic cycle(input din_t d);
        logic m_stall, m_flush;
        drive(d);
        #1;
        m_stall = m_valid && (m_e.resultsrc == 2'b01) && (m_e.rd != 5'd0)
                  && (m_e.rd == d.rs1 || m_e.rd == d.rs2);
        m_flush = m_stall || d.pcsrc;
        obs_stallf = StallF; obs_stalld = StallD; obs_fd = FlushD; obs_fe = FlushE;
        chk("StallF", 64'(StallF), 64'(m_stall));
        chk("StallD", 64'(StallD), 64'(m_stall));
        chk("FlushD", 64'(FlushD), 64'(d.pcsrc));
        chk("FlushE", 64'(FlushE), 64'(m_flush));
        @(posedge clk);
        if (d.reset || m_flush) begin
            m_e     = zero_din();
            m_valid = 1'b0;
        end else begin
            m_e     = d;
            m_valid = 1'b1;
        end
        #1;
        check_e_vs_model();
        $display("cyc t=%0t rst=%0b pcsrc=%0b rs1=%0d rs2=%0d rd=%0d -> stall=%0b flushE=%0b validE=%0b rdE=%0d",
                 $time, d.reset, d.pcsrc, d.rs1, d.rs2, d.rd, obs_stallf, obs_fe, ValidE, RdE);
    endtask

    row_t tbl[14];

    initial begin
        m_e     = zero_din();
        m_valid = 1'b0;

        // Reset state
        drive(zero_din());
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_e_vs_model();
        chk("reset StallF", 64'(StallF), 64'(0));
        chk("reset FlushE", 64'(FlushE), 64'(0));

        //         rst pcs rw rsrc  br jmp rs1 rs2 rd   stl fd fe  v  rw rd  br jmp
        tbl[0]  = mk(0, 0, 1, 2'b00, 0, 0, 1,  2,  3,   0,  0, 0,  1, 1, 3,  0, 0); // add x3,x1,x2
        tbl[1]  = mk(0, 0, 1, 2'b01, 0, 0, 1,  0,  5,   0,  0, 0,  1, 1, 5,  0, 0); // lw x5
        tbl[2]  = mk(0, 0, 1, 2'b00, 0, 0, 5,  1,  6,   1,  0, 1,  0, 0, 0,  0, 0); // uses x5 -> bubble
        tbl[3]  = mk(0, 0, 1, 2'b00, 0, 0, 5,  1,  6,   0,  0, 0,  1, 1, 6,  0, 0); // replayed
        tbl[4]  = mk(0, 0, 1, 2'b01, 0, 0, 0,  0,  0,   0,  0, 0,  1, 1, 0,  0, 0); // lw x0
        tbl[5]  = mk(0, 0, 1, 2'b00, 0, 0, 0,  0,  7,   0,  0, 0,  1, 1, 7,  0, 0); // x0 never stalls
        tbl[6]  = mk(0, 1, 1, 2'b00, 1, 1, 2,  3,  8,   0,  1, 1,  0, 0, 0,  0, 0); // taken branch
        tbl[7]  = mk(0, 0, 1, 2'b01, 0, 0, 0,  0,  9,   0,  0, 0,  1, 1, 9,  0, 0); // lw x9
        tbl[8]  = mk(0, 1, 1, 2'b00, 0, 0, 1,  9,  10,  1,  1, 1,  0, 0, 0,  0, 0); // load-use + redirect
        tbl[9]  = mk(0, 0, 1, 2'b01, 0, 0, 0,  0,  11,  0,  0, 0,  1, 1, 11, 0, 0); // lw x11
        tbl[10] = mk(1, 0, 1, 2'b00, 0, 0, 11, 0,  12,  1,  0, 1,  0, 0, 0,  0, 0); // reset mid-stall
        tbl[11] = mk(0, 0, 1, 2'b01, 0, 0, 11, 0,  12,  0,  0, 0,  1, 1, 12, 0, 0); // no leftover stall
        tbl[12] = mk(0, 0, 1, 2'b01, 0, 0, 28, 4,  13,  0,  0, 0,  1, 1, 13, 0, 0); // 28 vs 12: 5-bit compare
        tbl[13] = mk(0, 0, 1, 2'b00, 0, 0, 0,  13, 14,  1,  0, 1,  0, 0, 0,  0, 0); // Rs2 hazard

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].d);
            chk($sformatf("row%0d StallF", i), 64'(obs_stallf), 64'(tbl[i].exp_stall));
            chk($sformatf("row%0d StallD", i), 64'(obs_stalld), 64'(tbl[i].exp_stall));
            chk($sformatf("row%0d FlushD", i), 64'(obs_fd), 64'(tbl[i].exp_fd));
            chk($sformatf("row%0d FlushE", i), 64'(obs_fe), 64'(tbl[i].exp_fe));
            chk($sformatf("row%0d ValidE", i), 64'(ValidE), 64'(tbl[i].exp_valid));
            chk($sformatf("row%0d RegWriteE", i), 64'(RegWriteE), 64'(tbl[i].exp_rw));
            chk($sformatf("row%0d RdE", i), 64'(RdE), 64'(tbl[i].exp_rd));
            chk($sformatf("row%0d BranchE", i), 64'(BranchE), 64'(tbl[i].exp_br));
            chk($sformatf("row%0d JumpE", i), 64'(JumpE), 64'(tbl[i].exp_jmp));
        end

        // After a bubble, the cleared slot must not stall even when decode names x0
        cycle(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0).d);
        chk("post-bubble StallF", 64'(obs_stallf), 64'(0));

        // Randomized traffic over a small register set to provoke frequent hazards
        for (int i = 0; i < 400; i++) begin
            cycle(rand_din(5'd3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
